ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered PS/2 clock changes level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle cycles (1 ms at 100 MHz) that abort a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of 2 and at least 2.
REQ-004 SHALL have port CLK, input, 1 bit: system clock; the block has one clock only.
REQ-005 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port CLK_PS2_IN, input, 1 bit: raw PS/2 clock line, asynchronous.
REQ-007 SHALL have port DATA_PS2_IN, input, 1 bit: raw PS/2 data line, asynchronous.
REQ-008 SHALL have port READ_ENABLE, input, 1 bit: permits a new frame to start.
REQ-009 SHALL have port POP, input, 1 bit: dequeues the FIFO head.
REQ-010 SHALL have port CLEAR_OVERFLOW, input, 1 bit: clears OVERFLOW.
REQ-011 SHALL have port BYTE_OUT, output, 8 bits: data of the FIFO head.
REQ-012 SHALL have port ERR_OUT, output, 2 bits: FIFO head flags; bit0 = parity error, bit1 = stop error.
REQ-013 SHALL have ports EMPTY and FULL, outputs, 1 bit each: FIFO status.
REQ-014 SHALL have port COUNT, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have ports OVERFLOW (sticky) and TIMEOUT (one-cycle pulse), outputs, 1 bit each.

Function
REQ-016 SHALL pass both PS/2 lines through a 2-flop synchroniser before any use.
REQ-017 SHALL change the filtered clock level only after FILTER_LEN consecutive identical synchronised samples.
REQ-018 SHALL generate a one-cycle fall pulse on each filtered-clock 1->0 transition; a pulse shorter than FILTER_LEN cycles SHALL produce no pulse.
REQ-019 SHALL sample the synchronised data line only in the cycle that the fall pulse is asserted.
REQ-020 SHALL implement the states IDLE, DATA, PARITY and STOP.
REQ-021 IDLE: on a fall pulse with data=0 and READ_ENABLE=1, SHALL go to DATA with the bit counter at 0; on data=1 or READ_ENABLE=0, SHALL stay in IDLE.
REQ-022 DATA: each fall pulse SHALL shift data in LSB-first (shift right, new bit into [7]); the 8th pulse SHALL go to PARITY.
REQ-023 PARITY: the fall pulse SHALL set the parity error flag when data != ~^shift (odd parity), then go to STOP.
REQ-024 STOP: the fall pulse SHALL set the stop error flag when data=0, push {flags, byte} into the FIFO and return to IDLE.
REQ-025 Frames with error flags set SHALL still be pushed; the flags SHALL be cleared at every frame start.
REQ-026 SHALL clear the timeout counter on every fall pulse and while in IDLE.
REQ-027 Outside IDLE, when the timeout counter reaches TIMEOUT_CYCLES-1, SHALL return to IDLE, discard the partial frame and pulse TIMEOUT for one cycle.
REQ-028 READ_ENABLE deasserting mid-frame SHALL NOT abort that frame; it gates frame start only.
REQ-029 FIFO SHALL be show-ahead: BYTE_OUT/ERR_OUT show the head whenever EMPTY=0; EMPTY SHALL read 0 in the cycle after the stop-bit fall pulse.
REQ-030 POP with EMPTY=1 SHALL be ignored, with COUNT staying 0.
REQ-031 A push while FULL with no POP in the same cycle SHALL drop the new byte, leave the contents unchanged and set OVERFLOW.
REQ-032 A push and a POP in the same cycle SHALL both take effect, including when FULL, with COUNT unchanged.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 CLEAR_OVERFLOW SHALL clear OVERFLOW; if it coincides with a new overflow, set SHALL win.

Reset
REQ-035 RESET SHALL force state IDLE and clear shift register, bit counter, flags, timeout counter, FIFO pointers and filter counter.
REQ-036 After RESET, outputs SHALL be BYTE_OUT=0x00, ERR_OUT=00, EMPTY=1, FULL=0, COUNT=0, OVERFLOW=0, TIMEOUT=0.
REQ-037 RESET SHALL set the synchroniser and filtered clock to 1 (idle-high bus).
REQ-038 RESET mid-frame SHALL discard the frame, with no push and no TIMEOUT pulse.

Verification
REQ-039 Frame 0xA5, parity 1, stop 1 -> EMPTY=0, BYTE_OUT=0xA5, ERR_OUT=00, COUNT=1; POP -> EMPTY=1.
REQ-040 Frame 0x3C, parity 0, stop 1 -> ERR_OUT=01; frame 0x3C, parity 1, stop 0 -> ERR_OUT=10.
REQ-041 Start + 5 data bits, then bus idle for TIMEOUT_CYCLES -> a single TIMEOUT pulse, EMPTY=1; the next frame 0x12 is received with ERR_OUT=00.
REQ-042 With FIFO_DEPTH=4, 5 frames 0x01..0x05 and no POP -> COUNT=4, FULL=1, OVERFLOW=1, head=0x01; CLEAR_OVERFLOW -> OVERFLOW=0.
REQ-043 A 3-cycle low glitch on CLK_PS2_IN with FILTER_LEN=8 in IDLE -> no state change, EMPTY=1.
REQ-044 RESET after the 4th data bit, then frame 0x7E -> only 0x7E is in the FIFO, COUNT=1.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 device-to-host receiver with glitch filter, frame timeout and a
//   show-ahead receive FIFO. Single clock domain (CLK); both PS/2 lines are
//   treated as asynchronous and are synchronised before use.
//
//   Ports
//     CLK, RESET           system clock, synchronous active-high reset
//     CLK_PS2_IN           raw PS/2 clock line
//     DATA_PS2_IN          raw PS/2 data line
//     READ_ENABLE          allows a new frame to start (does not abort one)
//     POP                  dequeue FIFO head (ignored when empty)
//     CLEAR_OVERFLOW       clear sticky OVERFLOW (a new overflow wins)
//     BYTE_OUT, ERR_OUT    FIFO head: data byte, {stop_err, parity_err}
//     EMPTY, FULL, COUNT   FIFO status / occupancy
//     OVERFLOW             sticky, set when a received byte was dropped
//     TIMEOUT              one-cycle pulse when a partial frame is abandoned
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | waiting for a start bit (data=0 on a fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | checking the odd-parity bit
//   STOP   | checking the stop bit, pushing the frame
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CLK_PS2_IN,
  input  logic                          DATA_PS2_IN,
  input  logic                          READ_ENABLE,
  input  logic                          POP,
  input  logic                          CLEAR_OVERFLOW,
  output logic [7:0]                    BYTE_OUT,
  output logic [1:0]                    ERR_OUT,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERFLOW,
  output logic                          TIMEOUT
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // synchronisers, reset to the idle-high bus level
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= CLK_PS2_IN;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= DATA_PS2_IN;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: count consecutive samples that disagree with the current
  // filtered level; for a 1-bit signal these are all identical, so the level
  // flips after FILTER_LEN of them in a row.
  logic [FLT_W-1:0] r_filt_cnt;
  logic             r_clk_filt;
  logic             w_filt_done;
  logic             w_fall;

  assign w_filt_done = (r_filt_cnt == FLT_W'(FILTER_LEN - 1));
  // asserted in the cycle the filtered clock is about to go 1 -> 0
  assign w_fall      = r_clk_filt & ~r_clk_s2 & w_filt_done;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_filt_cnt <= '0;
      r_clk_filt <= 1'b1;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_done) begin
      r_filt_cnt <= '0;
      r_clk_filt <= r_clk_s2;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // frame FSM
  state_t           r_state, w_state_nxt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_par_err;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_timeout;
  logic             w_start;
  logic             w_push;
  logic             w_timeout;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_dat_s2 && READ_ENABLE) begin
          w_state_nxt = S_DATA;
          w_start     = 1'b1;
        end
      end
      S_DATA: begin
        if (w_fall && (r_bit_cnt == 3'd7)) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (w_fall) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A fall in the same cycle restarts the idle count, so it takes priority.
    if ((r_state != S_IDLE) && !w_fall &&
        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) begin
      w_state_nxt = S_IDLE;
      w_timeout   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_err <= 1'b0;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if ((r_state == S_IDLE) || w_fall || w_timeout) r_to_cnt <= '0;
      else                                            r_to_cnt <= r_to_cnt + 1'b1;
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_par_err <= 1'b0;
      end else if (w_fall && (r_state == S_DATA)) begin
        r_shift   <= {r_dat_s2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_fall && (r_state == S_PARITY)) begin
        r_par_err <= (r_dat_s2 != ~^r_shift);
      end
    end
  end

  // receive FIFO
  logic [9:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic           w_full, w_empty;
  logic           w_do_pop, w_do_push, w_ovf_set;
  logic [9:0]     w_push_word;
  logic [9:0]     w_head;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_do_pop    = POP && !w_empty;
  // a pop in the same cycle frees the slot even when full
  assign w_do_push   = w_push && (!w_full || w_do_pop);
  assign w_ovf_set   = w_push && w_full && !w_do_pop;
  // stop error is evaluated live on the stop-bit fall
  assign w_push_word = {~r_dat_s2, r_par_err, r_shift};

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_push_word;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)           r_overflow <= 1'b1;
      else if (CLEAR_OVERFLOW) r_overflow <= 1'b0;
    end
  end

  // storage is not reset, so the head is masked while empty
  assign w_head   = w_empty ? 10'd0 : r_mem[r_rd_ptr];
  assign BYTE_OUT = w_head[7:0];
  assign ERR_OUT  = w_head[9:8];
  assign EMPTY    = w_empty;
  assign FULL     = w_full;
  assign COUNT    = r_count;
  assign OVERFLOW = r_overflow;
  assign TIMEOUT  = r_timeout;

endmodule
